// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the parametrised sequential multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    localparam int unsigned MAX_WIDTH = 64;

    function automatic int unsigned calc_nslice(input int unsigned width, input int unsigned slice);
        return width / slice;
    endfunction

    // Magnitude of a width-bit two's-complement value; the most-negative value maps to 2^(width-1).
    function automatic logic [MAX_WIDTH-1:0] twos_mag(input logic [MAX_WIDTH-1:0] value,
                                                      input int unsigned width);
        logic [MAX_WIDTH-1:0] mask;
        mask = (width >= MAX_WIDTH) ? '1 : ((MAX_WIDTH'(1) << width) - MAX_WIDTH'(1));
        if (value[width-1]) begin
            return (~value + MAX_WIDTH'(1)) & mask;
        end
        return value & mask;
    endfunction

endpackage

// File: rtl/mult_slice.sv
// Combinational WIDTH x SLICE unsigned partial-product unit.
module mult_slice #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SLICE = 4
) (
    input  logic [WIDTH-1:0]       a,
    input  logic [SLICE-1:0]       b,
    output logic [WIDTH+SLICE-1:0] p
);

    localparam int unsigned PW = WIDTH + SLICE;

    assign p = PW'(a) * PW'(b);

endmodule

// File: rtl/seq_mult_param.sv
// Sequential multiplier: consumes SLICE bits of the multiplier per clock, optional signed mode,
// start/busy/done handshake with a held result register.
module seq_mult_param
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SLICE = 4
) (
    input  logic               clk,
    input  logic               reset_a,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   dataa,
    input  logic [WIDTH-1:0]   datab,
    output logic               busy,
    output logic               done_flag,
    output logic [2*WIDTH-1:0] product_out
);

    localparam int unsigned NSLICE = calc_nslice(WIDTH, SLICE);
    localparam int unsigned ACC_W  = 2 * WIDTH;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

    generate
        if (WIDTH < 2 || WIDTH > MAX_WIDTH || SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_params
            $error("seq_mult_param: illegal WIDTH/SLICE combination");
        end
    endgenerate

    state_t                 state;
    state_t                 state_next;
    logic [WIDTH-1:0]       a_mag;
    logic [WIDTH-1:0]       b_mag;
    logic                   neg;
    logic [WIDTH-1:0]       a_in_mag;
    logic [WIDTH-1:0]       b_in_mag;
    logic                   neg_in;
    logic [CNT_W-1:0]       cnt;
    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       acc_term;
    logic [SLICE-1:0]       b_chunk;
    logic [WIDTH+SLICE-1:0] partial;

    mult_slice #(
        .WIDTH(WIDTH),
        .SLICE(SLICE)
    ) u_mult_slice (
        .a(a_mag),
        .b(b_chunk),
        .p(partial)
    );

    always_comb begin
        a_in_mag = dataa;
        b_in_mag = datab;
        if (signed_mode) begin
            a_in_mag = WIDTH'(twos_mag(MAX_WIDTH'(dataa), WIDTH));
            b_in_mag = WIDTH'(twos_mag(MAX_WIDTH'(datab), WIDTH));
        end
        neg_in = signed_mode & (dataa[WIDTH-1] ^ datab[WIDTH-1]);
    end

    always_comb begin
        b_chunk  = b_mag[cnt*SLICE +: SLICE];
        acc_term = ACC_W'(partial) << (cnt * SLICE);
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == CNT_LAST) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_a) begin
            state       <= IDLE;
            a_mag       <= '0;
            b_mag       <= '0;
            neg         <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            product_out <= '0;
            done_flag   <= 1'b0;
        end else begin
            state     <= state_next;
            done_flag <= (state == FIN);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_mag <= a_in_mag;
                        b_mag <= b_in_mag;
                        neg   <= neg_in;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    acc <= acc + acc_term;
                    cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
                end
                // Negating zero yields zero, so no -0 special case is needed.
                FIN:     product_out <= neg ? -acc : acc;
                default: ;
            endcase
        end
    end

endmodule
